// File: rtl/w0rm_peripheral_bus_router.sv
// Routes the response of one outstanding core request from NUM_PORTS peripherals; optional timeout under W0RM_BUS_ROUTER_TIMEOUT_EN.
// Latency: response sampled in WAIT appears on bus_valid_o one cycle later; timeout fires after TIMEOUT_CYCLES silent WAIT cycles.
// Backpressure: none; a single transaction is in flight, and extra requests or unexpected responses are dropped and flagged.
module w0rm_peripheral_bus_router #(
    parameter int                    NUM_PORTS      = 4,
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    TIMEOUT_CYCLES = 16,
    parameter logic [DATA_WIDTH-1:0] ERR_DATA       = 32'hDEADBEEF
) (
    input  logic                            bus_clock,
    input  logic                            reset,
    input  logic                            mem_valid_i,
    input  logic                            mem_read_i,
    input  logic                            mem_write_i,
    input  logic [NUM_PORTS-1:0]            port_valid_i,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] port_data_i,
    input  logic                            clear_flags_i,
    output logic                            bus_valid_o,
    output logic [DATA_WIDTH-1:0]           bus_data_o,
    output logic                            bus_error_o,
    output logic [2:0]                      resp_port_o,
    output logic                            busy_o,
    output logic                            collision_o,
    output logic                            stray_o
);

    if (NUM_PORTS < 2 || NUM_PORTS > 8 || TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_cfg
        $error("w0rm_peripheral_bus_router: illegal NUM_PORTS or TIMEOUT_CYCLES");
    end

    typedef enum logic {ST_IDLE, ST_WAIT} state_t;

    state_t                state;
    logic                  req;
    logic                  hit;
    logic                  multi_hit;
    logic [2:0]            sel_idx;
    logic [DATA_WIDTH-1:0] sel_dat;
    logic                  tmo_fire;
    logic                  stray_evt;
    logic                  coll_evt;
    logic                  bus_error_q;

    assign req       = mem_valid_i && (mem_read_i || mem_write_i);
    assign hit       = |port_valid_i;
    assign multi_hit = (port_valid_i & (port_valid_i - NUM_PORTS'(1))) != '0;
    assign stray_evt = ((state == ST_IDLE) && hit) || ((state == ST_WAIT) && req);
    assign coll_evt  = (state == ST_WAIT) && multi_hit;

    // Walk from the top down so the lowest-index valid port is the last writer.
    always_comb begin
        sel_idx = '0;
        sel_dat = '0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            if (port_valid_i[k]) begin
                sel_idx = 3'(k);
                sel_dat = port_data_i[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

`ifdef W0RM_BUS_ROUTER_TIMEOUT_EN
    logic [7:0] tmo_cnt;

    // Fires on the TIMEOUT_CYCLES-th silent WAIT cycle; a response on that cycle still wins.
    assign tmo_fire    = (state == ST_WAIT) && !hit && (tmo_cnt == 8'(TIMEOUT_CYCLES - 1));
    assign bus_error_o = bus_error_q;

    always_ff @(posedge bus_clock or posedge reset) begin
        if (reset) begin
            tmo_cnt <= '0;
        end else if (state == ST_IDLE) begin
            tmo_cnt <= '0;
        end else if (!hit && !tmo_fire) begin
            tmo_cnt <= tmo_cnt + 8'd1;
        end
    end
`else
    assign tmo_fire    = 1'b0;
    assign bus_error_o = 1'b0;
`endif

    always_ff @(posedge bus_clock or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            bus_valid_o <= 1'b0;
            bus_data_o  <= '0;
            bus_error_q <= 1'b0;
            resp_port_o <= '0;
            busy_o      <= 1'b0;
            collision_o <= 1'b0;
            stray_o     <= 1'b0;
        end else begin
            bus_valid_o <= 1'b0;
            bus_error_q <= 1'b0;

            if (stray_evt)          stray_o <= 1'b1;
            else if (clear_flags_i) stray_o <= 1'b0;

            if (coll_evt)           collision_o <= 1'b1;
            else if (clear_flags_i) collision_o <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (req) begin
                        state  <= ST_WAIT;
                        busy_o <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (hit) begin
                        bus_valid_o <= 1'b1;
                        bus_data_o  <= sel_dat;
                        resp_port_o <= sel_idx;
                        state       <= ST_IDLE;
                        busy_o      <= 1'b0;
                    end else if (tmo_fire) begin
                        bus_valid_o <= 1'b1;
                        bus_error_q <= 1'b1;
                        bus_data_o  <= ERR_DATA;
                        resp_port_o <= 3'd7;
                        state       <= ST_IDLE;
                        busy_o      <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_w0rm_peripheral_bus_router.sv
// Directed bench for w0rm_peripheral_bus_router; handles both W0RM_BUS_ROUTER_TIMEOUT_EN builds.
module tb_w0rm_peripheral_bus_router;

    logic         bus_clock = 1'b0;
    logic         reset;
    logic         mem_valid_i, mem_read_i, mem_write_i;
    logic [3:0]   port_valid_i;
    logic [127:0] port_data_i;
    logic         clear_flags_i;
    logic         bus_valid_o;
    logic [31:0]  bus_data_o;
    logic         bus_error_o;
    logic [2:0]   resp_port_o;
    logic         busy_o, collision_o, stray_o;

    int total  = 0;
    int passes = 0;

    w0rm_peripheral_bus_router #(
        .NUM_PORTS(4), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16), .ERR_DATA(32'hDEADBEEF)
    ) dut (
        .bus_clock    (bus_clock),
        .reset        (reset),
        .mem_valid_i  (mem_valid_i),
        .mem_read_i   (mem_read_i),
        .mem_write_i  (mem_write_i),
        .port_valid_i (port_valid_i),
        .port_data_i  (port_data_i),
        .clear_flags_i(clear_flags_i),
        .bus_valid_o  (bus_valid_o),
        .bus_data_o   (bus_data_o),
        .bus_error_o  (bus_error_o),
        .resp_port_o  (resp_port_o),
        .busy_o       (busy_o),
        .collision_o  (collision_o),
        .stray_o      (stray_o)
    );

    always #5 bus_clock = ~bus_clock;

    task automatic step();
        @(posedge bus_clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Packs the visible output state for compact comparison: {valid, error, busy, coll, stray, port}
    function automatic logic [31:0] ctl();
        return {24'd0, bus_valid_o, bus_error_o, busy_o, collision_o, stray_o, resp_port_o};
    endfunction

    initial begin
        reset         = 1'b1;
        mem_valid_i   = 1'b0;
        mem_read_i    = 1'b0;
        mem_write_i   = 1'b0;
        port_valid_i  = 4'b0000;
        clear_flags_i = 1'b0;
        port_data_i   = {32'h33333333, 32'h00000055, 32'h11111111, 32'hA0A0A0A0};
        step();
        step();
        chk("reset_ctl", ctl(), 32'h0);
        chk("reset_data", bus_data_o, 32'h0);
        reset = 1'b0;
        step();

        // Read request; port 2 answers two cycles later
        mem_valid_i = 1'b1; mem_read_i = 1'b1;
        step();
        mem_valid_i = 1'b0; mem_read_i = 1'b0;
        chk("rd_busy", ctl(), {24'd0, 8'b00100_000});
        step();
        chk("rd_no_early_valid", ctl(), {24'd0, 8'b00100_000});
        port_valid_i = 4'b0100;
        step();
        port_valid_i = 4'b0000;
        chk("rd_resp_ctl", ctl(), {24'd0, 8'b10000_010});
        chk("rd_resp_data", bus_data_o, 32'h00000055);
        step();
        chk("rd_pulse_ctl", ctl(), {24'd0, 8'b00000_010});
        chk("rd_hold_data", bus_data_o, 32'h00000055);

        // Write request; ports 1 and 3 collide, port 1 wins
        mem_valid_i = 1'b1; mem_write_i = 1'b1;
        step();
        mem_valid_i = 1'b0; mem_write_i = 1'b0;
        port_valid_i = 4'b1010;
        step();
        port_valid_i = 4'b0000;
        chk("coll_ctl", ctl(), {24'd0, 8'b10010_001});
        chk("coll_data", bus_data_o, 32'h11111111);
        step();
        chk("coll_sticky", ctl(), {24'd0, 8'b00010_001});
        clear_flags_i = 1'b1;
        step();
        clear_flags_i = 1'b0;
        chk("coll_cleared", ctl(), {24'd0, 8'b00000_001});

        // Collision coincident with clear: set wins
        mem_valid_i = 1'b1; mem_read_i = 1'b1;
        step();
        mem_valid_i = 1'b0; mem_read_i = 1'b0;
        port_valid_i = 4'b0011; clear_flags_i = 1'b1;
        step();
        port_valid_i = 4'b0000; clear_flags_i = 1'b0;
        chk("coll_set_wins", ctl(), {24'd0, 8'b10010_000});
        chk("coll_p0_data", bus_data_o, 32'hA0A0A0A0);
        clear_flags_i = 1'b1;
        step();
        clear_flags_i = 1'b0;

        // Port 0 valid while idle is dropped
        port_valid_i = 4'b0001;
        step();
        port_valid_i = 4'b0000;
        chk("idle_stray", ctl(), {24'd0, 8'b00001_000});
        chk("idle_stray_data", bus_data_o, 32'hA0A0A0A0);
        clear_flags_i = 1'b1;
        step();
        clear_flags_i = 1'b0;
        chk("stray_cleared", ctl(), {24'd0, 8'b00000_000});

        // Response on the request cycle and a second request in WAIT are both stray
        mem_valid_i = 1'b1; mem_read_i = 1'b1; port_valid_i = 4'b0001;
        step();
        port_valid_i = 4'b0000;
        chk("reqcyc_stray", ctl(), {24'd0, 8'b00101_000});
        step();
        mem_valid_i = 1'b0; mem_read_i = 1'b0;
        chk("wait_req_busy", ctl(), {24'd0, 8'b00101_000});
        port_valid_i = 4'b1000;
        step();
        port_valid_i = 4'b0000;
        chk("p3_resp_ctl", ctl(), {24'd0, 8'b10001_011});
        chk("p3_resp_data", bus_data_o, 32'h33333333);
        clear_flags_i = 1'b1;
        step();
        clear_flags_i = 1'b0;

        // Silent peripheral
        mem_valid_i = 1'b1; mem_read_i = 1'b1;
        step();
        mem_valid_i = 1'b0; mem_read_i = 1'b0;
`ifdef W0RM_BUS_ROUTER_TIMEOUT_EN
        for (int i = 0; i < 15; i++) step();
        chk("tmo_not_yet", ctl(), {24'd0, 8'b00100_011});
        step();
        chk("tmo_ctl", ctl(), {24'd0, 8'b11000_111});
        chk("tmo_data", bus_data_o, 32'hDEADBEEF);
        step();
        chk("tmo_pulse", ctl(), {24'd0, 8'b00000_111});
        chk("tmo_hold", bus_data_o, 32'hDEADBEEF);

        // Response on the would-be timeout cycle wins
        mem_valid_i = 1'b1; mem_read_i = 1'b1;
        step();
        mem_valid_i = 1'b0; mem_read_i = 1'b0;
        for (int i = 0; i < 15; i++) step();
        port_valid_i = 4'b0010;
        step();
        port_valid_i = 4'b0000;
        chk("tmo_resp_wins", ctl(), {24'd0, 8'b10000_001});
        chk("tmo_resp_data", bus_data_o, 32'h11111111);
`else
        for (int i = 0; i < 20; i++) step();
        chk("notmo_still_busy", ctl(), {24'd0, 8'b00100_011});
        port_valid_i = 4'b0100;
        step();
        port_valid_i = 4'b0000;
        chk("notmo_late_resp", ctl(), {24'd0, 8'b10000_010});
        chk("notmo_late_data", bus_data_o, 32'h00000055);
`endif

        // Reset mid-WAIT abandons the transaction
        mem_valid_i = 1'b1; mem_write_i = 1'b1;
        step();
        mem_valid_i = 1'b0; mem_write_i = 1'b0;
        chk("pre_rst_busy", {31'd0, busy_o}, 32'd1);
        reset = 1'b1;
        #1;
        chk("async_rst_ctl", ctl(), 32'h0);
        chk("async_rst_data", bus_data_o, 32'h0);
        step();
        reset = 1'b0;
        port_valid_i = 4'b0001;
        step();
        port_valid_i = 4'b0000;
        chk("post_rst_stray", ctl(), {24'd0, 8'b00001_000});
        chk("post_rst_data", bus_data_o, 32'h0);
        step();
        chk("post_rst_quiet", ctl(), {24'd0, 8'b00001_000});

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule

// File: doc/w0rm_peripheral_bus_router.md
W0RM_PERIPHERAL_BUS_ROUTER -- requirements
Module: W0RM_Peripheral_Bus_Router

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 4, count of peripheral response ports (legal 2..8).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, response data width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 16, wait cycles before error response (legal 2..255).
REQ-004 SHALL have parameter ERR_DATA, default 32'hDEADBEEF, data returned on timeout.
REQ-005 SHALL have port bus_clock  input  1  sole clock; all logic on rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port mem_valid_i  input  1  core request strobe.
REQ-008 SHALL have port mem_read_i / mem_write_i  input  1 each  request type qualifiers.
REQ-009 SHALL have port port_valid_i  input  NUM_PORTS  per-peripheral response strobes.
REQ-010 SHALL have port port_data_i  input  NUM_PORTS*DATA_WIDTH  packed response data, port k at bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-011 SHALL have port clear_flags_i  input  1  clears sticky status flags.
REQ-012 SHALL have port bus_valid_o  output  1  one-cycle response strobe to core.
REQ-013 SHALL have port bus_data_o  output  DATA_WIDTH  response data to core.
REQ-014 SHALL have port bus_error_o  output  1  one-cycle timeout error strobe, coincident with bus_valid_o.
REQ-015 SHALL have port resp_port_o  output  3  index of responding port (7 on timeout).
REQ-016 SHALL have port busy_o  output  1  high while in WAIT.
REQ-017 SHALL have ports collision_o, stray_o  output  1 each  sticky status flags.

Function
REQ-018 SHALL implement states IDLE and WAIT; a request is mem_valid_i && (mem_read_i || mem_write_i).
REQ-019 SHALL go IDLE->WAIT on a request, clearing the timeout counter to 0.
REQ-020 SHALL, in WAIT, sample port_valid_i each cycle; on any set bit, select the lowest-index valid port, register its data onto bus_data_o, index onto resp_port_o, pulse bus_valid_o the next cycle, return to IDLE.
REQ-021 SHALL give latency of exactly one cycle from port_valid_i sampled in WAIT to bus_valid_o.
REQ-022 SHALL set collision_o when more than one port_valid_i bit is set on the accepted cycle; lowest index still wins.
REQ-023 SHALL set stray_o on any port_valid_i bit seen in IDLE (including the request cycle itself) and drop that response.
REQ-024 SHALL ignore requests arriving while in WAIT (single outstanding transaction) and set stray_o.
REQ-025 SHALL increment the timeout counter each WAIT cycle without a response; on reaching TIMEOUT_CYCLES, pulse bus_valid_o and bus_error_o next cycle with bus_data_o = ERR_DATA, resp_port_o = 7, return to IDLE.
REQ-026 SHALL prefer a response over timeout when both occur on the same cycle.
REQ-027 SHALL hold bus_data_o and resp_port_o stable between responses; bus_valid_o and bus_error_o are high for exactly one cycle.
REQ-028 SHALL clear sticky flags on clear_flags_i; a set event on the same cycle wins (flag stays 1).

Reset
REQ-029 SHALL, on reset asserted, immediately force state IDLE, counter 0, bus_valid_o 0, bus_data_o 0, bus_error_o 0, resp_port_o 0, busy_o 0, collision_o 0, stray_o 0.
REQ-030 SHALL abandon any in-flight WAIT on reset with no response issued; first legal request is the cycle after reset deasserts.

Configuration
REQ-031 SHALL, with macro W0RM_BUS_ROUTER_TIMEOUT_EN defined, include the timeout counter and REQ-025 behaviour.
REQ-032 SHALL, without W0RM_BUS_ROUTER_TIMEOUT_EN, omit the counter, remain in WAIT until a response, and tie bus_error_o to 0.

Verification
REQ-033 SHALL cover: read request, port 2 valid with 32'h00000055 two cycles later -> bus_valid_o one cycle after, bus_data_o=32'h00000055, resp_port_o=2.
REQ-034 SHALL cover: ports 1 and 3 valid same WAIT cycle -> port 1 data returned, collision_o=1 until clear_flags_i.
REQ-035 SHALL cover: request, no response, TIMEOUT_EN defined, TIMEOUT_CYCLES=16 -> bus_error_o and bus_valid_o pulse, data 32'hDEADBEEF, resp_port_o=7; same with macro undefined -> busy_o stays 1.
REQ-036 SHALL cover: port 0 valid while IDLE -> no bus_valid_o, stray_o=1.
REQ-037 SHALL cover: reset asserted mid-WAIT, port 0 response after release -> outputs zero, no bus_valid_o, stray_o=1.
